// File: rtl/inst_fetch.sv
// inst_fetch: IF stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches words over a req/ack instruction bus, buffers a
// returned word across IF stalls, and applies branch redirects (after the
// delay slot) and exception flushes.
// Optional build macro: IF_ADDR_ERR_EN (adds if_addr_err, misaligned-PC trap).
`timescale 1ns/1ps

module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'hBFC0_0000,
  parameter logic [31:0] ZERO_INST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
`ifdef IF_ADDR_ERR_EN
  output logic        if_addr_err,
`endif
  output logic        stallreq_if
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_buf_q, inst_buf_d;
  logic [XLEN-1:0]   br_target_q, br_target_d;
  logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
  logic              br_pending_q, br_pending_d;

  logic              addr_err;
  logic              br_take;
  logic              advance;
  logic [XLEN-1:0]   npc;

  // Stall bits owned by other stages are not used here.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  // Next-state, next-PC and bus/IF outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_buf_d   = inst_buf_q;
    br_target_d  = br_target_q;
    drop_addr_d  = drop_addr_q;
    br_pending_d = br_pending_q;
    ibus_req     = 1'b0;
`ifdef IF_ADDR_ERR_EN
    ibus_addr    = pc_q;
    addr_err     = (state_q == S_REQ) && (pc_q[1:0] != 2'b00);
`else
    ibus_addr    = {pc_q[XLEN-1:2], 2'b00};
    addr_err     = 1'b0;
`endif
    if_pc        = pc_q;
    if_inst      = ZERO_INST;
    stallreq_if  = 1'b0;
    advance      = 1'b0;

    br_take = branch_flag && !stall[2] && !flush;
    if (br_take)           npc = branch_target_addr;
    else if (br_pending_q) npc = br_target_q;
    else                   npc = pc_q + XLEN'(4);

    case (state_q)
      S_REQ: begin
        if (!addr_err) begin
          ibus_req = 1'b1;
          if (ibus_ack) begin
            if_inst = ibus_rdata;
            if (!stall[1]) begin
              advance = 1'b1;
            end else begin
              inst_buf_d = ibus_rdata;
              state_d    = S_HOLD;
            end
          end else begin
            stallreq_if = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if_inst = inst_buf_q;
        if (!stall[1]) begin
          advance = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        ibus_req    = 1'b1;
        ibus_addr   = drop_addr_q;
        stallreq_if = 1'b1;
        if (ibus_ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // A captured branch either redirects the advancing PC or waits as pending.
    if (advance) begin
      pc_d         = npc;
      br_pending_d = 1'b0;
    end else if (br_take) begin
      br_pending_d = 1'b1;
      br_target_d  = branch_target_addr;
    end

    // Flush overrides everything; an unacked request must keep its address.
    if (flush) begin
      pc_d         = flush_pc;
      br_pending_d = 1'b0;
      if_inst      = ZERO_INST;
      if (state_q == S_REQ && !addr_err && !ibus_ack) begin
        state_d     = S_DROP;
        drop_addr_d = ibus_addr;
      end else if (state_q != S_DROP) begin
        state_d = S_REQ;
      end
    end

    if (rst) begin
      ibus_req    = 1'b0;
      stallreq_if = 1'b0;
      if_inst     = ZERO_INST;
      if_pc       = RESET_ADDR;
      addr_err    = 1'b0;
    end
  end

`ifdef IF_ADDR_ERR_EN
  assign if_addr_err = addr_err;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_ADDR;
      inst_buf_q   <= '0;
      br_target_q  <= '0;
      drop_addr_q  <= RESET_ADDR;
      br_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_buf_q   <= inst_buf_d;
      br_target_q  <= br_target_d;
      drop_addr_q  <= drop_addr_d;
      br_pending_q <= br_pending_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed plan steps followed by randomized traffic, all
// checked against a transaction-level model of the IF stage.
`timescale 1ns/1ps

module tb_inst_fetch;

  localparam logic [31:0] RESET_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] ZERO_INST  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target_addr;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
`ifdef IF_ADDR_ERR_EN
  logic        if_addr_err;
`endif

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
    .ibus_rdata(ibus_rdata), .if_pc(if_pc), .if_inst(if_inst),
`ifdef IF_ADDR_ERR_EN
    .if_addr_err(if_addr_err),
`endif
    .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: PC, held instruction, an old fetch to discard, pending branch.
  logic [31:0] m_pc, m_buf, m_old, m_bt;
  bit          m_held, m_disc, m_bp;
  logic [31:0] e_inst, e_addr;
  bit          e_req, e_stall, e_err;

  function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef IF_ADDR_ERR_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
`ifdef IF_ADDR_ERR_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_req();
    if (m_disc) return 1'b1;
    if (m_held) return 1'b0;
    return !misaligned(m_pc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check the outputs.
  task automatic drive(input bit ack, input logic [31:0] rd, input logic [5:0] st,
                       input bit br, input logic [31:0] tgt,
                       input bit fl, input logic [31:0] fpc);
    @(negedge clk);
    ibus_ack = ack; ibus_rdata = rd; stall = st;
    branch_flag = br; branch_target_addr = tgt; flush = fl; flush_pc = fpc;
    #1;
    e_err   = !m_disc && !m_held && misaligned(m_pc);
    e_req   = model_req();
    e_stall = 1'b0;
    e_inst  = ZERO_INST;
    e_addr  = bus_addr(m_pc);
    if (m_disc) begin
      e_addr  = m_old;
      e_stall = 1'b1;
    end else if (m_held) begin
      e_inst = m_buf;
    end else if (!e_err) begin
      e_stall = !ack;
      if (ack) e_inst = rd;
    end
    if (fl) e_inst = ZERO_INST;
    chk("ibus_req", 32'(ibus_req), 32'(e_req));
    chk("stallreq_if", 32'(stallreq_if), 32'(e_stall));
    chk("if_inst", if_inst, e_inst);
    chk("if_pc", if_pc, m_pc);
    if (e_req) chk("ibus_addr", ibus_addr, e_addr);
`ifdef IF_ADDR_ERR_EN
    chk("if_addr_err", 32'(if_addr_err), 32'(e_err));
`endif
  endtask

  // Advance the model across the coming rising edge.
  task automatic update();
    bit          normal, deliv, cap;
    logic [31:0] tgt;
    normal = !m_disc && !m_held && !misaligned(m_pc);
    deliv  = (normal && ibus_ack) || m_held;
    cap    = branch_flag && !stall[2] && !flush;
    tgt    = cap ? branch_target_addr : (m_bp ? m_bt : m_pc + 32'd4);
    if (flush) begin
      if (normal && !ibus_ack) begin
        m_disc = 1'b1;
        m_old  = bus_addr(m_pc);
      end else if (m_disc && ibus_ack) begin
        m_disc = 1'b0;
      end
      m_held = 1'b0;
      m_pc   = flush_pc;
      m_bp   = 1'b0;
    end else begin
      if (m_disc && ibus_ack) m_disc = 1'b0;
      if (deliv && !stall[1]) begin
        m_held = 1'b0;
        m_pc   = tgt;
        m_bp   = 1'b0;
      end else begin
        if (normal && ibus_ack) begin
          m_held = 1'b1;
          m_buf  = ibus_rdata;
        end
        if (cap) begin
          m_bp = 1'b1;
          m_bt = branch_target_addr;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic step(input bit ack, input logic [31:0] rd, input logic [5:0] st);
    drive(ack, rd, st, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0; branch_flag = 1'b0;
    branch_target_addr = '0; ibus_ack = 1'b0; ibus_rdata = '0;
    m_pc = RESET_ADDR; m_buf = '0; m_old = '0; m_bt = '0;
    m_held = 1'b0; m_disc = 1'b0; m_bp = 1'b0;

    // Reset values
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ibus_req", 32'(ibus_req), 32'd0);
    chk("rst_stallreq", 32'(stallreq_if), 32'd0);
    chk("rst_if_inst", if_inst, ZERO_INST);
    chk("rst_if_pc", if_pc, RESET_ADDR);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: first fetch acked immediately
    step(1'b1, 32'h2401_0001, 6'b0);
    chk("t1_addr", ibus_addr, 32'hBFC0_0000);
    chk("t1_inst", if_inst, 32'h2401_0001);
    chk("t1_pc", if_pc, 32'hBFC0_0000);
    update();

    // 2: three wait states
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hDEAD_0000, 6'b0);
      chk("t2_stallreq", 32'(stallreq_if), 32'd1);
      chk("t2_addr", ibus_addr, 32'hBFC0_0004);
      update();
    end
    step(1'b1, 32'h0000_0044, 6'b0);
    chk("t2_ack_stallreq", 32'(stallreq_if), 32'd0);
    update();

    // 3: IF stalled for two cycles from the ack of 0xBFC00008
    step(1'b1, 32'h1111_1111, 6'b000010);
    chk("t3_addr", ibus_addr, 32'hBFC0_0008);
    update();
    step(1'b0, 32'h0, 6'b000010);
    chk("t3_hold_req", 32'(ibus_req), 32'd0);
    chk("t3_hold_inst", if_inst, 32'h1111_1111);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t3_rel_inst", if_inst, 32'h1111_1111);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t3_next_addr", ibus_addr, 32'hBFC0_000C);
    update();

    // 4: branch while the delay slot is still unacked
    drive(1'b0, 32'h0, 6'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
    update();
    step(1'b1, 32'h2222_2222, 6'b0);
    chk("t4_slot_inst", if_inst, 32'h2222_2222);
    chk("t4_slot_pc", if_pc, 32'hBFC0_000C);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t4_target", ibus_addr, 32'hBFC0_0100);
    update();

    // 5: flush while a fetch is outstanding
    drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t5_drop_addr", ibus_addr, 32'hBFC0_0100);
    update();
    step(1'b1, 32'h3333_3333, 6'b0);
    chk("t5_discard", if_inst, ZERO_INST);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t5_handler", ibus_addr, 32'hBFC0_0380);
    update();

`ifdef IF_ADDR_ERR_EN
    // 6: misaligned handler address
    drive(1'b1, 32'h4444_4444, 6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0382);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t6_err", 32'(if_addr_err), 32'd1);
    chk("t6_noreq", 32'(ibus_req), 32'd0);
    chk("t6_pc", if_pc, 32'hBFC0_0382);
    update();
    drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
    update();
    step(1'b0, 32'h0, 6'b0);
    chk("t6_cleared", 32'(if_addr_err), 32'd0);
    update();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          ack, br, fl;
      logic [5:0]  st;
      logic [31:0] fpc;
      ack = model_req() && ($urandom_range(0, 2) == 0);
      st  = 6'($urandom_range(0, 63));
      st[1] = ($urandom_range(0, 3) == 0);
      st[2] = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 31) == 0);
      fpc = 32'hBFC0_0000 | ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 7) == 0) fpc[1:0] = 2'($urandom_range(1, 3));
      drive(ack, $urandom, st, br, 32'h8000_0000 | ($urandom & 32'h00FF_FFFC), fl, fpc);
      update();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
